muldiv_unit: RTL

//   Parametrised iterative multiply/divide unit implementing the RV32M ops (MUL/MULH/MULHSU/

---
 rtl/muldiv_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// one bit per clock, with single-cycle fast paths for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = '1;

    function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? -v : v;
    endfunction

    // MUL/MULH/MULHSU/DIV/REM treat rs1 as signed; MULHSU treats rs2 as unsigned.
    function automatic logic op_signed_a(input logic [2:0] o);
        return !(o[0] && (o[1] || o[2]));
    endfunction

    function automatic logic op_signed_b(input logic [2:0] o);
        return op_signed_a(o) && (o != 3'b010);
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic             sa_q, sa_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] ms_q, ms_d;
    logic [WIDTH-1:0] res_d;
    logic             dz_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   trial;
    logic [2*WIDTH-1:0] prod_nx;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   hi_nx, lo_nx;
    logic [WIDTH-1:0]   final_res;

    always_comb begin
        sa    = op_signed_a(op) && a[WIDTH-1];
        sb    = op_signed_b(op) && b[WIDTH-1];
        abs_a = cond_neg_w(a, sa);
        abs_b = cond_neg_w(b, sb);

        // One iteration of either core, computed from the current partial state.
        sum   = {1'b0, hi_q} + {1'b0, ms_q};
        trial = {1'b0, hi_q, lo_q[WIDTH-1]} - {2'b00, ms_q};
        if (lo_q[0]) prod_nx = {sum, lo_q[WIDTH-1:1]};
        else         prod_nx = {1'b0, hi_q, lo_q[WIDTH-1:1]};

        if (op_q[2]) begin
            if (!trial[WIDTH+1]) begin
                hi_nx = trial[WIDTH-1:0];
                lo_nx = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_nx = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
                lo_nx = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_nx = prod_nx[2*WIDTH-1:WIDTH];
            lo_nx = prod_nx[WIDTH-1:0];
        end

        prod_fin = cond_neg_2w({hi_nx, lo_nx}, neg_q);
        if (!op_q[2])
            final_res = (op_q[1:0] == 2'b00) ? prod_fin[WIDTH-1:0] : prod_fin[2*WIDTH-1:WIDTH];
        else if (!op_q[1])
            final_res = cond_neg_w(lo_nx, neg_q);
        else
            final_res = cond_neg_w(hi_nx, sa_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        sa_d    = sa_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        ms_d    = ms_q;
        res_d   = result;
        dz_d    = dz;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    sa_d    = sa;
                    neg_d   = sa ^ sb;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = op[2] ? abs_a : abs_b;
                    ms_d    = op[2] ? abs_b : abs_a;
                    state_d = CALC;
                    if (op[2] && (b == '0)) begin
                        res_d   = op[1] ? a : ALL_ONE;
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else if (op[2] && !op[0] && (a == MIN_NEG) && (b == ALL_ONE)) begin
                        res_d   = op[1] ? '0 : a;
                        dz_d    = 1'b0;
                        state_d = DONE;
                    end
                end
            end
            CALC: begin
                hi_d  = hi_nx;
                lo_d  = lo_nx;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_d   = final_res;
                    dz_d    = 1'b0;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            sa_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            ms_q    <= '0;
            result  <= '0;
            dz      <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            sa_q    <= sa_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            ms_q    <= ms_d;
            result  <= res_d;
            dz      <= dz_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

endmodule
